// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the processor clock run-control block.
// Optional build macro used by this slice: CLK_CTRL_CYCLE_COUNT_EN.
package clk_ctrl_pkg;

   localparam int DIV_W_DEFAULT = 16;
   localparam int MIN_HALF      = 1;

   typedef enum logic [1:0] {
      HALT = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   // Half-period for a divisor: odd values round down, 0 and 1 behave as 2.
   function automatic int unsigned half_of(input int unsigned div);
      if ((div >> 1) < MIN_HALF)
         return MIN_HALF;
      return div >> 1;
   endfunction

endpackage

// File: rtl/clock_div_ctrl_if.sv
// Configuration / run-control / status bundle of clock_div_ctrl.
// master = board-side controller, slave = clock_div_ctrl.
interface clock_div_ctrl_if #(
   parameter int DIV_W = clk_ctrl_pkg::DIV_W_DEFAULT
);
   logic             cfg_valid;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_ready;
   logic             run_en;
   logic             step;
   logic             outclk;
   logic             tick;
   logic             halted;
   logic [31:0]      cycle_cnt;

   modport master (
      output cfg_valid, cfg_div, run_en, step,
      input  cfg_ready, outclk, tick, halted, cycle_cnt
   );

   modport slave (
      input  cfg_valid, cfg_div, run_en, step,
      output cfg_ready, outclk, tick, halted, cycle_cnt
   );
endinterface

// File: rtl/clk_phase_gen.sv
// Phase counter for the generated clock: counts 0..half-1 per phase and
// toggles the phase on wrap; boundary flags the last cycle of the low phase.
module clk_phase_gen #(
   parameter int               DIV_W     = 16,
   parameter logic [DIV_W-1:0] INIT_HALF = DIV_W'(5)
) (
   input  logic             refclk,
   input  logic             resetn,
   input  logic [DIV_W-1:0] half,
   input  logic             load_half,
   input  logic             enable,
   input  logic             restart,
   output logic             phase,
   output logic             tick,
   output logic             boundary
);

   logic [DIV_W-1:0] half_q;
   logic [DIV_W-1:0] cnt;
   logic             at_end;

   // at_end uses the half in force now, so a load never shortens the current period.
   assign at_end   = (cnt == half_q - DIV_W'(1));
   assign boundary = at_end & ~phase;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; the later tick assignment intentionally overrides the default.
   always_ff @(posedge refclk or negedge resetn) begin
      if (!resetn) begin
         half_q <= INIT_HALF;
         cnt    <= '0;
         phase  <= 1'b0;
         tick   <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (load_half)
            half_q <= half;
         if (restart) begin
            cnt   <= '0;
            phase <= 1'b1;
            tick  <= 1'b1;
         end else if (enable) begin
            if (at_end) begin
               cnt   <= '0;
               phase <= ~phase;
               tick  <= ~phase;
            end else begin
               cnt <= cnt + DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/clock_div_ctrl.sv
// Run-control and divisor controller for the CPU clock (RUN / HALT / STEP).
// Define CLK_CTRL_CYCLE_COUNT_EN to build the outclk period counter.
module clock_div_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEFAULT,
   parameter int DEFAULT_DIV = 10
) (
   input logic             refclk,
   input logic             resetn,
   clock_div_ctrl_if.slave bus
);

   localparam logic [DIV_W-1:0] INIT_HALF = DIV_W'(half_of(DEFAULT_DIV));

   state_t           state;
   logic             step_q;
   logic             pend_valid;
   logic [DIV_W-1:0] pend_div;
   logic             halted_q;

   logic             phase;
   logic             tick;
   logic             boundary;
   logic             step_rise;
   logic             period_end;
   logic             go_halt;
   logic             leave_halt;
   logic             apply;
   logic             enable;
   logic [DIV_W-1:0] pend_half;

   always_comb begin
      step_rise  = bus.step & ~step_q;
      period_end = (state != HALT) & boundary;
      go_halt    = period_end & ~bus.run_en;
      leave_halt = (state == HALT) & (bus.run_en | step_rise);
      // A pending divisor lands on a period boundary, or straight away when parked.
      apply      = pend_valid & ((state == HALT) | period_end);
      enable     = (state != HALT) & ~go_halt;
      pend_half  = DIV_W'(half_of(32'(pend_div)));
   end

   clk_phase_gen #(
      .DIV_W     (DIV_W),
      .INIT_HALF (INIT_HALF)
   ) u_phase (
      .refclk    (refclk),
      .resetn    (resetn),
      .half      (pend_half),
      .load_half (apply),
      .enable    (enable),
      .restart   (leave_halt),
      .phase     (phase),
      .tick      (tick),
      .boundary  (boundary)
   );

   always_ff @(posedge refclk or negedge resetn) begin
      if (!resetn) begin
         state      <= HALT;
         halted_q   <= 1'b1;
         step_q     <= 1'b0;
         pend_valid <= 1'b0;
         pend_div   <= '0;
      end else begin
         step_q <= bus.step;
         unique case (state)
            HALT: begin
               if (bus.run_en) begin
                  state    <= RUN;
                  halted_q <= 1'b0;
               end else if (step_rise) begin
                  state    <= STEP;
                  halted_q <= 1'b0;
               end
            end
            RUN: begin
               if (go_halt) begin
                  state    <= HALT;
                  halted_q <= 1'b1;
               end
            end
            STEP: begin
               // Step edges inside the period are not queued; run_en decides the exit.
               if (period_end) begin
                  state    <= bus.run_en ? RUN : HALT;
                  halted_q <= ~bus.run_en;
               end
            end
            default: begin
               state    <= HALT;
               halted_q <= 1'b1;
            end
         endcase

         if (apply)
            pend_valid <= 1'b0;
         else if (bus.cfg_valid && !pend_valid) begin
            pend_valid <= 1'b1;
            pend_div   <= bus.cfg_div;
         end
      end
   end

   assign bus.outclk    = phase;
   assign bus.tick      = tick;
   assign bus.halted    = halted_q;
   assign bus.cfg_ready = ~pend_valid;

`ifdef CLK_CTRL_CYCLE_COUNT_EN
   logic [31:0] cycle_q;

   always_ff @(posedge refclk or negedge resetn) begin
      if (!resetn)
         cycle_q <= '0;
      else if (tick)
         cycle_q <= cycle_q + 32'd1;
   end

   assign bus.cycle_cnt = cycle_q;
`else
   assign bus.cycle_cnt = '0;
`endif

endmodule
